// File: rtl/anemo_sortie_arbiter_if.sv
// Handshake and Avalon-MM write bus between the two Sortie requesters,
// the arbiter, and the PIO s1 slave.
interface anemo_sortie_arbiter_if;
  logic        req0;
  logic [7:0]  data0;
  logic        ack0;
  logic        req1;
  logic [7:0]  data1;
  logic        ack1;
  logic [1:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write_n;
  logic [31:0] avm_writedata;
  logic        busy;
  logic        last_owner;

  modport master (
    input  req0, data0, req1, data1,
    output ack0, ack1, avm_address, avm_chipselect, avm_write_n,
           avm_writedata, busy, last_owner
  );

  modport slave (
    output req0, data0, req1, data1,
    input  ack0, ack1, avm_address, avm_chipselect, avm_write_n,
           avm_writedata, busy, last_owner
  );
endinterface

// File: rtl/anemo_sortie_arbiter.sv
// Round-robin Avalon-MM write master sharing the 8-bit Sortie PIO register
// between the anemometer path (requester 0) and the alarm path (requester 1).
module anemo_sortie_arbiter #(
  parameter int HOLD_CYCLES = 50000,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  anemo_sortie_arbiter_if.master  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ZERO  = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] HOLD_LOAD =
    (HOLD_CYCLES > 0) ? CNT_WIDTH'(HOLD_CYCLES - 1) : {CNT_WIDTH{1'b0}};

  state_t               state_r;
  logic [CNT_WIDTH-1:0] cnt_r;
  logic [7:0]           byte_r;
  logic                 chipselect_r;
  logic                 write_n_r;
  logic                 ack0_r;
  logic                 ack1_r;
  logic                 busy_r;
  logic                 last_owner_r;

  logic                 grant_valid_s;
  logic                 grant_sel_s;
  logic [7:0]           grant_byte_s;

  // Round-robin pick: a lone request wins, a tie goes to whoever was not served last.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_sel_s   = 1'b0;
    if (bus.req0 && bus.req1) begin
      grant_valid_s = 1'b1;
      grant_sel_s   = ~last_owner_r;
    end else if (bus.req0) begin
      grant_valid_s = 1'b1;
      grant_sel_s   = 1'b0;
    end else if (bus.req1) begin
      grant_valid_s = 1'b1;
      grant_sel_s   = 1'b1;
    end else begin
      grant_valid_s = 1'b0;
      grant_sel_s   = 1'b0;
    end
  end

  assign grant_byte_s = grant_sel_s ? bus.data1 : bus.data0;

  // Arbitration FSM; every bus and handshake output is a register set here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      cnt_r        <= CNT_ZERO;
      byte_r       <= 8'h00;
      chipselect_r <= 1'b0;
      write_n_r    <= 1'b1;
      ack0_r       <= 1'b0;
      ack1_r       <= 1'b0;
      busy_r       <= 1'b0;
      last_owner_r <= 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (grant_valid_s) begin
            state_r      <= ST_WRITE;
            byte_r       <= grant_byte_s;
            chipselect_r <= 1'b1;
            write_n_r    <= 1'b0;
            ack0_r       <= ~grant_sel_s;
            ack1_r       <= grant_sel_s;
            busy_r       <= 1'b1;
            last_owner_r <= grant_sel_s;
          end else begin
            state_r      <= ST_IDLE;
            chipselect_r <= 1'b0;
            write_n_r    <= 1'b1;
            ack0_r       <= 1'b0;
            ack1_r       <= 1'b0;
            busy_r       <= 1'b0;
          end
        end

        ST_WRITE: begin
          chipselect_r <= 1'b0;
          write_n_r    <= 1'b1;
          ack0_r       <= 1'b0;
          ack1_r       <= 1'b0;
          // With no hold interval, go straight back to arbitration.
          if (HOLD_CYCLES == 0) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end else begin
            state_r <= ST_HOLD;
            cnt_r   <= HOLD_LOAD;
            busy_r  <= 1'b1;
          end
        end

        ST_HOLD: begin
          chipselect_r <= 1'b0;
          write_n_r    <= 1'b1;
          ack0_r       <= 1'b0;
          ack1_r       <= 1'b0;
          if (cnt_r == CNT_ZERO) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end else begin
            state_r <= ST_HOLD;
            cnt_r   <= cnt_r - CNT_ONE;
            busy_r  <= 1'b1;
          end
        end

        default: begin
          state_r      <= ST_IDLE;
          cnt_r        <= CNT_ZERO;
          chipselect_r <= 1'b0;
          write_n_r    <= 1'b1;
          ack0_r       <= 1'b0;
          ack1_r       <= 1'b0;
          busy_r       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.avm_address    = 2'b00;
  assign bus.avm_chipselect = chipselect_r;
  assign bus.avm_write_n    = write_n_r;
  assign bus.avm_writedata  = {24'h000000, byte_r};
  assign bus.ack0           = ack0_r;
  assign bus.ack1           = ack1_r;
  assign bus.busy           = busy_r;
  assign bus.last_owner     = last_owner_r;

endmodule

// File: tb/tb_anemo_sortie_arbiter.sv
// Scoreboard bench: two arbiters (hold 4 and hold 0) share clk/reset; expected
// writes are queued by the stimulus and popped by per-instance bus monitors.
module tb_anemo_sortie_arbiter;

  typedef struct {
    logic [7:0] b;
    logic       own;
    int         gap;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   errors;
  int   checks;
  int   n4;
  int   n0;
  int   last4;
  int   last0;
  exp_t q4[$];
  exp_t q0[$];
  exp_t e4;
  exp_t e0;

  anemo_sortie_arbiter_if i4 ();
  anemo_sortie_arbiter_if i0 ();

  anemo_sortie_arbiter #(.HOLD_CYCLES(4), .CNT_WIDTH(16)) dut_h4 (
    .clk   (clk),
    .reset (reset),
    .bus   (i4.master)
  );

  anemo_sortie_arbiter #(.HOLD_CYCLES(0), .CNT_WIDTH(16)) dut_h0 (
    .clk   (clk),
    .reset (reset),
    .bus   (i0.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push4(input logic [7:0] b, input logic own, input int gap);
    exp_t e;
    e.b = b; e.own = own; e.gap = gap;
    q4.push_back(e);
  endtask

  task automatic push0(input logic [7:0] b, input logic own, input int gap);
    exp_t e;
    e.b = b; e.own = own; e.gap = gap;
    q0.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor for the hold-4 instance
  always @(negedge clk) begin
    if (!reset) begin
      if (i4.avm_chipselect) begin
        checks++;
        if (q4.size() == 0) begin
          errors++;
          $display("FAIL h4_unexpected_write: got data=%h expected no write", i4.avm_writedata);
        end else begin
          e4 = q4.pop_front();
          if (i4.avm_writedata !== {24'h000000, e4.b} || i4.avm_write_n !== 1'b0) begin
            errors++;
            $display("FAIL h4_write: got data=%h wn=%b expected data=%h wn=0",
                     i4.avm_writedata, i4.avm_write_n, e4.b);
          end
          checks++;
          if ({i4.ack1, i4.ack0} !== (e4.own ? 2'b10 : 2'b01)) begin
            errors++;
            $display("FAIL h4_ack: got ack1/ack0=%b%b expected owner %0d", i4.ack1, i4.ack0, e4.own);
          end
          checks++;
          if (i4.last_owner !== e4.own) begin
            errors++;
            $display("FAIL h4_last_owner: got %b expected %b", i4.last_owner, e4.own);
          end
          if (e4.gap != 0) begin
            checks++;
            if (cyc - last4 != e4.gap) begin
              errors++;
              $display("FAIL h4_spacing: got %0d expected %0d", cyc - last4, e4.gap);
            end
          end
        end
        last4 = cyc;
        n4++;
      end else if (i4.ack0 || i4.ack1) begin
        checks++;
        errors++;
        $display("FAIL h4_ack_without_write: got ack1/ack0=%b%b expected 00", i4.ack1, i4.ack0);
      end
    end
  end

  // Monitor for the zero-hold instance
  always @(negedge clk) begin
    if (!reset) begin
      if (i0.avm_chipselect) begin
        checks++;
        if (q0.size() == 0) begin
          errors++;
          $display("FAIL h0_unexpected_write: got data=%h expected no write", i0.avm_writedata);
        end else begin
          e0 = q0.pop_front();
          if (i0.avm_writedata !== {24'h000000, e0.b} || i0.avm_write_n !== 1'b0) begin
            errors++;
            $display("FAIL h0_write: got data=%h wn=%b expected data=%h wn=0",
                     i0.avm_writedata, i0.avm_write_n, e0.b);
          end
          checks++;
          if ({i0.ack1, i0.ack0} !== (e0.own ? 2'b10 : 2'b01)) begin
            errors++;
            $display("FAIL h0_ack: got ack1/ack0=%b%b expected owner %0d", i0.ack1, i0.ack0, e0.own);
          end
          checks++;
          if (i0.last_owner !== e0.own) begin
            errors++;
            $display("FAIL h0_last_owner: got %b expected %b", i0.last_owner, e0.own);
          end
          if (e0.gap != 0) begin
            checks++;
            if (cyc - last0 != e0.gap) begin
              errors++;
              $display("FAIL h0_spacing: got %0d expected %0d", cyc - last0, e0.gap);
            end
          end
        end
        last0 = cyc;
        n0++;
      end else if (i0.ack0 || i0.ack1) begin
        checks++;
        errors++;
        $display("FAIL h0_ack_without_write: got ack1/ack0=%b%b expected 00", i0.ack1, i0.ack0);
      end
    end
  end

  initial begin
    int  acks;
    bit  found;
    int  snap;
    errors = 0; checks = 0; n4 = 0; n0 = 0; last4 = 0; last0 = 0;
    i4.req0 = 1'b0; i4.req1 = 1'b0; i4.data0 = 8'h00; i4.data1 = 8'h00;
    i0.req0 = 1'b0; i0.req1 = 1'b0; i0.data0 = 8'h00; i0.data1 = 8'h00;
    reset = 1'b1;

    // 1: reset values, then 20 quiet cycles
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_cs",        {31'd0, i4.avm_chipselect}, 32'd0);
    chk("rst_write_n",   {31'd0, i4.avm_write_n},    32'd1);
    chk("rst_address",   {30'd0, i4.avm_address},    32'd0);
    chk("rst_writedata", i4.avm_writedata,           32'd0);
    chk("rst_acks",      {30'd0, i4.ack1, i4.ack0},  32'd0);
    chk("rst_busy",      {31'd0, i4.busy},           32'd0);
    chk("rst_last_owner",{31'd0, i4.last_owner},     32'd1);
    chk("rst_h0_last_owner", {31'd0, i0.last_owner}, 32'd1);
    repeat (20) @(negedge clk);
    chk("idle_no_writes", n4 + n0, 32'd0);

    // 2: single write, busy window, no rewrite after drop
    tick();
    i4.req0 = 1'b1; i4.data0 = 8'hA5;
    push4(8'hA5, 1'b0, 0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (i4.ack0) found = 1'b1;
    end
    chk("t2_ack0_seen", {31'd0, found}, 32'd1);
    chk("t2_write_busy", {31'd0, i4.busy}, 32'd1);
    i4.req0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t2_busy_hold", {31'd0, i4.busy}, 32'd1);
    end
    @(negedge clk);
    chk("t2_busy_released", {31'd0, i4.busy}, 32'd0);
    repeat (10) @(negedge clk);
    chk("t2_single_write", n4, 32'd1);

    // 3: simultaneous requests alternate 0,1,0 spaced 6 cycles
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    i4.req0 = 1'b1; i4.data0 = 8'h11;
    i4.req1 = 1'b1; i4.data1 = 8'h22;
    push4(8'h11, 1'b0, 0);
    push4(8'h22, 1'b1, 6);
    push4(8'h11, 1'b0, 6);
    acks = 0;
    for (int i = 0; i < 60 && acks < 3; i++) begin
      @(negedge clk);
      if (i4.ack0 || i4.ack1) acks++;
    end
    i4.req0 = 1'b0; i4.req1 = 1'b0;
    chk("t3_three_acks", acks, 32'd3);
    repeat (10) @(negedge clk);
    chk("t3_queue_drained", q4.size(), 32'd0);

    // 4: zero hold, req1 held with data counting per ack
    tick();
    i0.req1 = 1'b1; i0.data1 = 8'h01;
    push0(8'h01, 1'b1, 0);
    push0(8'h02, 1'b1, 2);
    push0(8'h03, 1'b1, 2);
    acks = 0;
    for (int i = 0; i < 30 && acks < 3; i++) begin
      @(negedge clk);
      if (i0.ack1) begin
        acks++;
        if (acks == 3) i0.req1 = 1'b0;
        else i0.data1 = 8'(acks + 1);
      end
    end
    chk("t4_three_acks", acks, 32'd3);
    repeat (6) @(negedge clk);
    chk("t4_writes", n0, 32'd3);
    chk("t4_last_owner", {31'd0, i0.last_owner}, 32'd1);

    // 5: reset during hold with req0 still high
    tick();
    i4.req0 = 1'b1; i4.data0 = 8'h5A;
    push4(8'h5A, 1'b0, 0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (i4.ack0) found = 1'b1;
    end
    chk("t5_ack0_seen", {31'd0, found}, 32'd1);
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("t5_rst_cs",      {31'd0, i4.avm_chipselect}, 32'd0);
    chk("t5_rst_write_n", {31'd0, i4.avm_write_n},    32'd1);
    chk("t5_rst_acks",    {30'd0, i4.ack1, i4.ack0},  32'd0);
    chk("t5_rst_busy",    {31'd0, i4.busy},           32'd0);
    i4.data0 = 8'h5B;
    push4(8'h5B, 1'b0, 0);
    tick();
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("t5_pre_sample_cs", {31'd0, i4.avm_chipselect}, 32'd0);
    @(negedge clk);
    chk("t5_fresh_ack0", {31'd0, i4.ack0}, 32'd1);
    i4.req0 = 1'b0;

    // 6: one-cycle pulse during hold is ignored
    tick();
    snap = n4;
    i4.req0 = 1'b1; i4.data0 = 8'h77;
    tick();
    i4.req0 = 1'b0;
    repeat (15) @(negedge clk);
    chk("t6_no_write", n4 - snap, 32'd0);
    chk("t6_queue_empty", q4.size() + q0.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
